// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller sitting beside the decode stage.
// Sequences PC, IF/ID and ID/EX registers: freezes on bus hold, flushes the
// wrong path after a taken jump, and inserts bubbles on load-use hazards.
// A jump that arrives while the bus is holding is remembered and replayed
// in the first cycle after the hold drops.
module pipe_hazard_ctrl #(
  parameter int FLUSH_CYCLES    = 2,
  parameter int LU_STALL_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  id2ctrl_rs1_addr_i,
  input  logic [4:0]  id2ctrl_rs2_addr_i,
  input  logic        id2ctrl_rs1_used_i,
  input  logic        id2ctrl_rs2_used_i,
  input  logic [4:0]  ex2ctrl_rd_addr_i,
  input  logic        ex2ctrl_is_load_i,
  input  logic        ex2ctrl_jump_i,
  input  logic [31:0] ex2ctrl_jump_addr_i,
  input  logic        bus2ctrl_hold_i,
  output logic        ctrl2pc_hold_o,
  output logic        ctrl2ifid_hold_o,
  output logic        ctrl2idex_hold_o,
  output logic        ctrl2ifid_flush_o,
  output logic        ctrl2idex_flush_o,
  output logic        ctrl2pc_jump_o,
  output logic [31:0] ctrl2pc_jump_addr_o,
  output logic [1:0]  ctrl_state_o
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2,
    ST_HOLD  = 2'd3
  } state_e;

  localparam int MAX_C = (FLUSH_CYCLES > LU_STALL_CYCLES) ? FLUSH_CYCLES : LU_STALL_CYCLES;
  localparam int CW    = (MAX_C > 1) ? $clog2(MAX_C + 1) : 1;
  localparam logic [CW-1:0] FLUSH_INIT = CW'(FLUSH_CYCLES - 1);
  localparam logic [CW-1:0] LU_INIT    = CW'(LU_STALL_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pend_q, pend_d;
  logic [31:0]   pend_addr_q, pend_addr_d;

  logic          lu_hit;
  logic          run_mode;
  logic          eff_jump;
  logic [31:0]   eff_addr;
  logic          pc_hold, ifid_hold, idex_hold;
  logic          ifid_flush, idex_flush;
  logic          jump;
  logic [31:0]   jump_addr;

  // Load-use hazard: EX is loading a register the decoded instruction reads.
  always_comb begin
    lu_hit = ex2ctrl_is_load_i && (ex2ctrl_rd_addr_i != 5'd0) &&
             ((id2ctrl_rs1_used_i && (id2ctrl_rs1_addr_i == ex2ctrl_rd_addr_i)) ||
              (id2ctrl_rs2_used_i && (id2ctrl_rs2_addr_i == ex2ctrl_rd_addr_i)));
  end

  // Next-state and control outputs; RUN priority logic is shared by states that preempt into it.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pend_d      = pend_q;
    pend_addr_d = pend_addr_q;
    pc_hold     = 1'b0;
    ifid_hold   = 1'b0;
    idex_hold   = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    jump        = 1'b0;
    jump_addr   = 32'd0;
    run_mode    = 1'b0;
    eff_jump    = ex2ctrl_jump_i;
    eff_addr    = ex2ctrl_jump_addr_i;

    case (state_q)
      ST_RUN: begin
        run_mode = 1'b1;
      end
      ST_STALL: begin
        if (bus2ctrl_hold_i || ex2ctrl_jump_i) begin
          run_mode = 1'b1;
        end else begin
          pc_hold    = 1'b1;
          ifid_hold  = 1'b1;
          idex_flush = 1'b1;
          cnt_d      = cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) state_d = ST_RUN;
        end
      end
      ST_FLUSH: begin
        if (bus2ctrl_hold_i) begin
          pc_hold   = 1'b1;
          ifid_hold = 1'b1;
          idex_hold = 1'b1;
          cnt_d     = '0;
          state_d   = ST_HOLD;
        end else begin
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
          cnt_d      = cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) state_d = ST_RUN;
        end
      end
      ST_HOLD: begin
        if (bus2ctrl_hold_i) begin
          pc_hold   = 1'b1;
          ifid_hold = 1'b1;
          idex_hold = 1'b1;
          if (ex2ctrl_jump_i && !pend_q) begin
            pend_d      = 1'b1;
            pend_addr_d = ex2ctrl_jump_addr_i;
          end
        end else begin
          run_mode = 1'b1;
          eff_jump = pend_q || ex2ctrl_jump_i;
          eff_addr = pend_q ? pend_addr_q : ex2ctrl_jump_addr_i;
          pend_d   = 1'b0;
        end
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase

    if (run_mode) begin
      if (bus2ctrl_hold_i) begin
        pc_hold   = 1'b1;
        ifid_hold = 1'b1;
        idex_hold = 1'b1;
        cnt_d     = '0;
        state_d   = ST_HOLD;
        if (ex2ctrl_jump_i) begin
          pend_d      = 1'b1;
          pend_addr_d = ex2ctrl_jump_addr_i;
        end
      end else if (eff_jump) begin
        jump       = 1'b1;
        jump_addr  = eff_addr;
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
        cnt_d      = FLUSH_INIT;
        state_d    = (FLUSH_CYCLES > 1) ? ST_FLUSH : ST_RUN;
      end else if (lu_hit) begin
        pc_hold    = 1'b1;
        ifid_hold  = 1'b1;
        idex_flush = 1'b1;
        cnt_d      = LU_INIT;
        state_d    = (LU_STALL_CYCLES > 1) ? ST_STALL : ST_RUN;
      end else begin
        cnt_d   = '0;
        state_d = ST_RUN;
      end
    end
  end

  // State, counter and pending-jump registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      cnt_q       <= '0;
      pend_q      <= 1'b0;
      pend_addr_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pend_q      <= pend_d;
      pend_addr_q <= pend_addr_d;
    end
  end

  // Outputs are forced low while reset is asserted, whatever the inputs do.
  always_comb begin
    ctrl2pc_hold_o      = rst_n & pc_hold;
    ctrl2ifid_hold_o    = rst_n & ifid_hold;
    ctrl2idex_hold_o    = rst_n & idex_hold;
    ctrl2ifid_flush_o   = rst_n & ifid_flush;
    ctrl2idex_flush_o   = rst_n & idex_flush;
    ctrl2pc_jump_o      = rst_n & jump;
    ctrl2pc_jump_addr_o = rst_n ? jump_addr : 32'd0;
    ctrl_state_o        = state_q;
  end

endmodule
